// File: rtl/irq_pkg.sv
// Shared constants for the machine interrupt controller: MMIO word offsets,
// mcause codes and the request FSM state encoding.
package irq_pkg;

  localparam logic [5:0] OFF_MSIP        = 6'd0;
  localparam logic [5:0] OFF_MTIMECMP_LO = 6'd2;
  localparam logic [5:0] OFF_MTIMECMP_HI = 6'd3;
  localparam logic [5:0] OFF_MTIME_LO    = 6'd4;
  localparam logic [5:0] OFF_MTIME_HI    = 6'd5;
  localparam logic [5:0] OFF_EXT_PEND    = 6'd6;
  localparam logic [5:0] OFF_EXT_EN      = 6'd7;
  localparam logic [5:0] OFF_CLAIM       = 6'd8;

  localparam logic [31:0] CAUSE_MEI = 32'h8000_000B;
  localparam logic [31:0] CAUSE_MSI = 32'h8000_0003;
  localparam logic [31:0] CAUSE_MTI = 32'h8000_0007;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_mtimer.sv
// 64-bit mtime/mtimecmp pair with tick prescaler; mtip is the unsigned
// compare of the two registers.
module irq_mtimer
  import irq_pkg::*;
#(
  parameter int TICK_DIV = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        bus_we,
  input  logic [5:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [63:0] mtime,
  output logic [63:0] mtimecmp,
  output logic        mtip
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0] presc;
  logic          tick;
  logic          wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi;

  assign tick       = (presc == PW'(TICK_DIV - 1));
  assign wr_time_lo = bus_we && (bus_addr == OFF_MTIME_LO);
  assign wr_time_hi = bus_we && (bus_addr == OFF_MTIME_HI);
  assign wr_cmp_lo  = bus_we && (bus_addr == OFF_MTIMECMP_LO);
  assign wr_cmp_hi  = bus_we && (bus_addr == OFF_MTIMECMP_HI);
  assign mtip       = (mtime >= mtimecmp);

  always_ff @(posedge clk) begin
    if (rst) begin
      presc    <= '0;
      mtime    <= '0;
      mtimecmp <= '1;
    end else begin
      presc <= tick ? '0 : presc + PW'(1);
      // a software write to either half swallows a coincident tick
      if (wr_time_lo)      mtime[31:0]  <= bus_wdata;
      else if (wr_time_hi) mtime[63:32] <= bus_wdata;
      else if (tick)       mtime        <= mtime + 64'd1;
      if (wr_cmp_lo) mtimecmp[31:0]  <= bus_wdata;
      if (wr_cmp_hi) mtimecmp[63:32] <= bus_wdata;
    end
  end

endmodule

// File: rtl/machine_irq_ctrl.sv
// Machine interrupt source: software/timer/external pending logic, claim port
// and the request handshake toward the exception unit.
//   state   | meaning
//   IDLE    | waiting for a pending source while mie_en=1
//   REQ     | irq_req high, cause frozen until ack or the source clears
//   SERVICE | trap in progress, no new requests until mret
module machine_irq_ctrl
  import irq_pkg::*;
#(
  parameter int N_EXT    = 8,
  parameter int TICK_DIV = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       bus_addr,
  input  logic             bus_we,
  input  logic             bus_re,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata,
  input  logic [N_EXT-1:0] ext_irq,
  input  logic             mie_en,
  output logic             irq_req,
  output logic [31:0]      irq_cause,
  input  logic             irq_ack,
  input  logic             mret
);

  logic [63:0]      mtime, mtimecmp;
  logic             mtip, msip, meip, any_pend, lat_pend, claim_rd;
  logic [N_EXT-1:0] ext_s1, ext_s2, ext_s3, ext_pend, ext_en;
  logic [N_EXT-1:0] rise, active, claim_mask;
  logic [31:0]      claim_id, win_cause, rd_mux;
  irq_state_e       state;

  irq_mtimer #(.TICK_DIV(TICK_DIV)) u_mtimer (
    .clk      (clk),
    .rst      (rst),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .mtime    (mtime),
    .mtimecmp (mtimecmp),
    .mtip     (mtip)
  );

  assign rise     = ext_s2 & ~ext_s3;
  assign active   = ext_pend & ext_en;
  assign meip     = |active;
  assign any_pend = meip | msip | mtip;
  assign claim_rd = bus_re && (bus_addr == OFF_CLAIM);
  assign win_cause = meip ? CAUSE_MEI : (msip ? CAUSE_MSI : CAUSE_MTI);

  // walk downward so the lowest active line is the one left standing
  always_comb begin
    claim_id   = '0;
    claim_mask = '0;
    for (int i = N_EXT - 1; i >= 0; i--) begin
      if (active[i]) begin
        claim_id      = 32'(i + 1);
        claim_mask    = '0;
        claim_mask[i] = 1'b1;
      end
    end
  end

  always_comb begin
    case (irq_cause)
      CAUSE_MEI: lat_pend = meip;
      CAUSE_MSI: lat_pend = msip;
      CAUSE_MTI: lat_pend = mtip;
      default:   lat_pend = 1'b0;
    endcase
  end

  always_comb begin
    case (bus_addr)
      OFF_MSIP:        rd_mux = {31'b0, msip};
      OFF_MTIMECMP_LO: rd_mux = mtimecmp[31:0];
      OFF_MTIMECMP_HI: rd_mux = mtimecmp[63:32];
      OFF_MTIME_LO:    rd_mux = mtime[31:0];
      OFF_MTIME_HI:    rd_mux = mtime[63:32];
      OFF_EXT_PEND:    rd_mux = 32'(ext_pend);
      OFF_EXT_EN:      rd_mux = 32'(ext_en);
      OFF_CLAIM:       rd_mux = claim_id;
      default:         rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ext_s1    <= '0;
      ext_s2    <= '0;
      ext_s3    <= '0;
      ext_pend  <= '0;
      ext_en    <= '0;
      msip      <= 1'b0;
      bus_rdata <= '0;
    end else begin
      ext_s1 <= ext_irq;
      ext_s2 <= ext_s1;
      ext_s3 <= ext_s2;
      // a new edge on the claimed line re-sets the bit in the same cycle
      ext_pend <= (ext_pend & ~(claim_rd ? claim_mask : '0)) | rise;
      if (bus_we && (bus_addr == OFF_EXT_EN)) ext_en <= bus_wdata[N_EXT-1:0];
      if (bus_we && (bus_addr == OFF_MSIP))   msip   <= bus_wdata[0];
      if (bus_re) bus_rdata <= rd_mux;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      irq_req   <= 1'b0;
      irq_cause <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mie_en && any_pend) begin
            state     <= REQ;
            irq_req   <= 1'b1;
            irq_cause <= win_cause;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state   <= SERVICE;
            irq_req <= 1'b0;
          end else if (!lat_pend) begin
            state   <= IDLE;
            irq_req <= 1'b0;
          end
        end
        SERVICE: begin
          if (mret) state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          irq_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_machine_irq_ctrl.sv
// Bench for machine_irq_ctrl: register vector table, directed handshake
// sequences, and randomized timer/claim rounds against an arithmetic model.
module tb_machine_irq_ctrl;

  localparam logic [5:0] A_MSIP = 6'd0, A_CMP_LO = 6'd2, A_CMP_HI = 6'd3;
  localparam logic [5:0] A_TIME_LO = 6'd4, A_TIME_HI = 6'd5, A_PEND = 6'd6;
  localparam logic [5:0] A_EN = 6'd7, A_CLAIM = 6'd8;
  localparam logic [31:0] C_MEI = 32'h8000000B, C_MSI = 32'h80000003, C_MTI = 32'h80000007;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  bus_addr = '0;
  logic        bus_we = 1'b0, bus_re = 1'b0;
  logic [31:0] bus_wdata = '0;
  logic [31:0] bus_rdata;
  logic [7:0]  ext_irq = '0;
  logic        mie_en = 1'b1;
  logic        irq_req;
  logic [31:0] irq_cause;
  logic        irq_ack = 1'b0, mret = 1'b0;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[13];

  logic [31:0] d, v, h, t;
  logic [7:0]  p, e, pend_m;
  int          idle, lw, seen, nexp;
  int          exp_ids[$];

  machine_irq_ctrl #(.N_EXT(8), .TICK_DIV(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus_addr (bus_addr),
    .bus_we   (bus_we),
    .bus_re   (bus_re),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .ext_irq  (ext_irq),
    .mie_en   (mie_en),
    .irq_req  (irq_req),
    .irq_cause(irq_cause),
    .irq_ack  (irq_ack),
    .mret     (mret)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tickn(input int n);
    repeat (n) tick();
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] dat);
    bus_addr = a; bus_wdata = dat; bus_we = 1'b1;
    tick();
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [5:0] a, output logic [31:0] dat);
    bus_addr = a; bus_re = 1'b1;
    tick();
    bus_re = 1'b0;
    dat = bus_rdata;
  endtask

  task automatic wait_req(input int budget, output int seen_cyc);
    int k = 0;
    while (!irq_req && k < budget) begin
      tick();
      k++;
    end
    seen_cyc = irq_req ? cyc : -1;
  endtask

  task automatic pulse_ext(input logic [7:0] m);
    ext_irq = m;
    tickn(3);
    ext_irq = '0;
    tickn(4);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{A_MSIP,   32'hFFFFFFFF, 32'h00000001};
    vecs[1]  = '{A_MSIP,   32'h00000002, 32'h00000000};
    vecs[2]  = '{6'd1,     32'h0000DEAD, 32'h00000000};
    vecs[3]  = '{A_CMP_LO, 32'h12345678, 32'h12345678};
    vecs[4]  = '{A_CMP_HI, 32'h9ABCDEF0, 32'h9ABCDEF0};
    vecs[5]  = '{A_CMP_LO, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[6]  = '{A_CMP_HI, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[7]  = '{A_EN,     32'hFFFFFFFF, 32'h000000FF};
    vecs[8]  = '{A_EN,     32'h00000000, 32'h00000000};
    vecs[9]  = '{A_PEND,   32'hFFFFFFFF, 32'h00000000};
    vecs[10] = '{A_CLAIM,  32'h00000005, 32'h00000000};
    vecs[11] = '{6'd9,     32'h00000001, 32'h00000000};
    vecs[12] = '{6'd63,    32'hA5A5A5A5, 32'h00000000};

    // reset and 100 idle cycles
    tickn(3);
    rst = 1'b0;
    chk("reset_irq_req", irq_req, 0);
    chk("reset_irq_cause", irq_cause, 0);
    chk("reset_rdata", bus_rdata, 0);
    tickn(100);
    chk("idle_no_req", irq_req, 0);
    rd(A_TIME_LO, d);
    chk("mtime_after_100", d, 100);

    // register write/readback table
    mie_en = 1'b0;
    for (int i = 0; i < 13; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd(vecs[i].addr, d);
      chk($sformatf("reg_vec%0d", i), d, vecs[i].exp);
    end
    mie_en = 1'b1;

    // mtime carry and write-beats-tick
    wr(A_TIME_HI, 32'h0);
    wr(A_TIME_LO, 32'hFFFFFFFF);
    tick();
    rd(A_TIME_LO, d);
    chk("wrap_lo", d, 0);
    rd(A_TIME_HI, d);
    chk("wrap_hi", d, 1);
    wr(A_TIME_LO, 32'h1234);
    rd(A_TIME_LO, d);
    chk("write_wins_tick", d, 32'h1234);
    rd(A_TIME_LO, d);
    chk("tick_after_write", d, 32'h1235);

    // random timer rounds: mtime = written + elapsed cycles; irq when mtime reaches cmp
    for (int r = 0; r < 8; r++) begin
      h = $urandom_range(0, 32'hFFFFFFFE);
      v = $urandom_range(0, 32'h7FFFFFFF);
      idle = $urandom_range(0, 20);
      wr(A_TIME_HI, h);
      wr(A_TIME_LO, v);
      lw = cyc;
      tickn(idle);
      rd(A_TIME_LO, d);
      chk($sformatf("rand_mtime%0d", r), d, v + 32'(cyc - 1 - lw));
      t = $urandom_range(3, 40);
      wr(A_TIME_HI, 32'h0);
      wr(A_TIME_LO, 32'h0);
      lw = cyc;
      wr(A_CMP_HI, 32'h0);
      wr(A_CMP_LO, t);
      wait_req(60, seen);
      chk($sformatf("rand_irq_seen%0d", r), irq_req, 1);
      chk($sformatf("rand_irq_delay%0d", r), 32'(seen - lw), t + 1);
      chk($sformatf("rand_irq_cause%0d", r), irq_cause, C_MTI);
      wr(A_CMP_HI, 32'hFFFFFFFF);
      tickn(2);
      chk($sformatf("rand_irq_drop%0d", r), irq_req, 0);
    end

    // timer request, ack, mret re-request
    mie_en = 1'b0;
    wr(A_TIME_HI, 32'h0);
    wr(A_TIME_LO, 32'd1000);
    wr(A_CMP_HI, 32'h0);
    wr(A_CMP_LO, 32'd20);
    tick();
    chk("mie_blocks", irq_req, 0);
    mie_en = 1'b1;
    tick();
    chk("timer_req", irq_req, 1);
    chk("timer_cause", irq_cause, C_MTI);
    mret = 1'b1; tick(); mret = 1'b0;
    chk("mret_in_req_ignored", irq_req, 1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("ack_drops_req", irq_req, 0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    tickn(3);
    chk("service_hold", irq_req, 0);
    mret = 1'b1; tick(); mret = 1'b0;
    chk("mret_idle", irq_req, 0);
    tick();
    chk("rereq", irq_req, 1);
    chk("rereq_cause", irq_cause, C_MTI);

    // external claims
    wr(A_CMP_HI, 32'hFFFFFFFF);
    tick();
    chk("timer_src_clear", irq_req, 0);
    wr(A_EN, 32'h28);
    pulse_ext(8'h29);
    wait_req(10, seen);
    chk("ext_req", irq_req, 1);
    chk("ext_cause", irq_cause, C_MEI);
    rd(A_PEND, d);
    chk("ext_pend", d, 32'h29);
    rd(A_CLAIM, d); chk("claim_first", d, 4);
    rd(A_CLAIM, d); chk("claim_second", d, 6);
    rd(A_CLAIM, d); chk("claim_none", d, 0);
    tickn(2);
    chk("ext_req_drop", irq_req, 0);
    rd(A_PEND, d);
    chk("ext_pend_left", d, 32'h01);

    // edge landing on the claim cycle keeps the bit pending
    wr(A_EN, 32'h02);
    pulse_ext(8'h02);
    ext_irq = 8'h02;
    tickn(2);
    rd(A_CLAIM, d); chk("claim_coincident", d, 2);
    rd(A_CLAIM, d); chk("claim_repend", d, 2);
    rd(A_CLAIM, d); chk("claim_empty", d, 0);
    ext_irq = 8'h00;
    tickn(2);
    chk("coinc_req_drop", irq_req, 0);

    // read and write on the same cycle
    bus_addr = A_EN; bus_wdata = 32'hF0; bus_we = 1'b1; bus_re = 1'b1;
    tick();
    bus_we = 1'b0; bus_re = 1'b0;
    chk("rw_prewrite", bus_rdata, 32'h02);
    rd(A_EN, d);
    chk("rw_written", d, 32'hF0);

    // msip beats timer; msip cleared in REQ hands over to timer
    mie_en = 1'b0;
    wr(A_CMP_HI, 32'h0);
    wr(A_CMP_LO, 32'h0);
    wr(A_MSIP, 32'h1);
    tick();
    chk("mie_blocks_msip", irq_req, 0);
    mie_en = 1'b1;
    tick();
    chk("msip_req", irq_req, 1);
    chk("msip_cause", irq_cause, C_MSI);
    mie_en = 1'b0;
    tickn(3);
    chk("req_held_mie0", irq_req, 1);
    mie_en = 1'b1;
    wr(A_MSIP, 32'h0);
    tick();
    chk("msip_clear_drop", irq_req, 0);
    tick();
    chk("timer_follows", irq_req, 1);
    chk("timer_follows_cause", irq_cause, C_MTI);

    // reset from SERVICE
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("service_entered", irq_req, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_irq_req", irq_req, 0);
    chk("rst_rdata", bus_rdata, 0);
    rd(A_EN, d);     chk("rst_ext_en", d, 0);
    rd(A_CMP_LO, d); chk("rst_cmp_lo", d, 32'hFFFFFFFF);
    rd(A_CMP_HI, d); chk("rst_cmp_hi", d, 32'hFFFFFFFF);
    rd(A_PEND, d);   chk("rst_pend", d, 0);
    rd(A_MSIP, d);   chk("rst_msip", d, 0);
    chk("rst_no_req", irq_req, 0);
    wr(A_MSIP, 32'h1);
    tick();
    chk("rst_idle_req", irq_req, 1);
    chk("rst_idle_cause", irq_cause, C_MSI);
    wr(A_MSIP, 32'h0);
    tickn(2);
    chk("rst_msip_drop", irq_req, 0);

    // random claim rounds: claims come out as ascending enabled pending IDs
    pend_m = '0;
    for (int r = 0; r < 6; r++) begin
      p = 8'($urandom_range(0, 255));
      e = 8'($urandom_range(0, 255));
      wr(A_EN, 32'(e));
      pulse_ext(p);
      pend_m = pend_m | p;
      rd(A_PEND, d);
      chk($sformatf("rand_pend%0d", r), d, 32'(pend_m));
      exp_ids.delete();
      for (int i = 0; i < 8; i++)
        if (pend_m[i] && e[i]) exp_ids.push_back(i + 1);
      exp_ids.push_back(0);
      nexp = exp_ids.size();
      for (int k = 0; k < nexp; k++) begin
        rd(A_CLAIM, d);
        chk($sformatf("rand_claim%0d_%0d", r, k), d, 32'(exp_ids[k]));
      end
      pend_m = pend_m & ~e;
      rd(A_PEND, d);
      chk($sformatf("rand_pend_after%0d", r), d, 32'(pend_m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
